// File: rtl/inst_prefetch_if.sv
// inst_prefetch_if: AXI4 read address (AR) and read data (R) channels between the prefetcher and instruction memory.
//   master modport: drives AR* and RREADY, samples ARREADY and R*
//   slave modport:  drives ARREADY and R*, samples AR* and RREADY
interface inst_prefetch_if #(
    parameter int ID_W     = 1,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARUSER_W = 1,
    parameter int RUSER_W  = 4
);
    logic [ID_W-1:0]     ARID;
    logic [ADDR_W-1:0]   ARADDR;
    logic [7:0]          ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic [1:0]          ARLOCK;
    logic [3:0]          ARCACHE;
    logic [2:0]          ARPROT;
    logic [3:0]          ARQOS;
    logic [ARUSER_W-1:0] ARUSER;
    logic                ARVALID;
    logic                ARREADY;
    logic [ID_W-1:0]     RID;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic [RUSER_W-1:0]  RUSER;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RUSER, RVALID,
        output RREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARQOS, ARUSER, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RUSER, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/inst_prefetch.sv
// inst_prefetch: AXI4 instruction prefetcher issuing block-aligned INCR bursts into a first-word-fall-through FIFO.
//   CLK, RST (async, active-low)     clock and reset
//   EXEC                             run enable; no new burst while low
//   FLUSH, FLUSH_PC                  one-cycle redirect: clears the FIFO, discards in-flight beats
//   INST_VALID/INST_READY/INST/INST_PC  decode-side handshake with head word and its address
//   BUSY                             an AXI transaction is in progress
//   ERR                              sticky, set by any delivered beat with a non-OKAY response
//   M_AXI                            AXI4 read master (AR and R channels)
module inst_prefetch #(
    parameter int          C_M_AXI_THREAD_ID_WIDTH = 1,
    parameter int          C_M_AXI_ADDR_WIDTH      = 32,
    parameter int          C_M_AXI_DATA_WIDTH      = 32,
    parameter int          C_M_AXI_ARUSER_WIDTH    = 1,
    parameter int          C_M_AXI_RUSER_WIDTH     = 4,
    parameter int          C_BURST_LEN             = 4,
    parameter int          C_FIFO_DEPTH            = 8,
    parameter logic [31:0] C_RESET_PC              = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EXEC,
    input  logic        FLUSH,
    input  logic [31:0] FLUSH_PC,
    output logic        INST_VALID,
    input  logic        INST_READY,
    output logic [31:0] INST,
    output logic [31:0] INST_PC,
    output logic        BUSY,
    output logic        ERR,
    inst_prefetch_if.master M_AXI
);
    localparam int AW = $clog2(C_FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d, araddr_q, araddr_d, beat_pc_q, beat_pc_d;
    logic [7:0]  arlen_q, arlen_d;
    logic        flush_pend_q, flush_pend_d, err_q, err_d;
    logic [AW:0] count_q, count_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [31:0] inst_mem [C_FIFO_DEPTH];
    logic [31:0] pc_mem [C_FIFO_DEPTH];
    logic [31:0] word_off, beats;
    logic        issue, beat, push, pop, unused_ok;

    // Bursts stop at the next block boundary, so a burst never straddles a block (or a 4 KB page)
    assign word_off = (fetch_pc_q >> 2) & 32'(C_BURST_LEN - 1);
    assign beats    = 32'(C_BURST_LEN) - word_off;
    // Space for the whole burst is reserved up front so RREADY never has to drop
    assign issue    = EXEC && !FLUSH && (32'(C_FIFO_DEPTH) - 32'(count_q) >= beats);
    assign beat     = M_AXI.RVALID && M_AXI.RREADY;
    assign push     = beat && state_q == DATA && !FLUSH;
    assign pop      = INST_VALID && INST_READY;

    assign INST_VALID = count_q != '0;
    assign INST       = INST_VALID ? inst_mem[rd_q] : '0;
    assign INST_PC    = INST_VALID ? pc_mem[rd_q] : '0;
    assign BUSY       = state_q != IDLE;
    assign ERR        = err_q;

    assign M_AXI.ARID    = '0;
    assign M_AXI.ARADDR  = araddr_q;
    assign M_AXI.ARLEN   = arlen_q;
    assign M_AXI.ARSIZE  = 3'b010;
    assign M_AXI.ARBURST = 2'b01;
    assign M_AXI.ARLOCK  = 2'b00;
    assign M_AXI.ARCACHE = 4'b0011;
    assign M_AXI.ARPROT  = 3'b000;
    assign M_AXI.ARQOS   = 4'b0000;
    assign M_AXI.ARUSER  = '0;
    assign M_AXI.ARVALID = state_q == ADDR;
    assign M_AXI.RREADY  = state_q == DATA || state_q == DRAIN;

    assign unused_ok = ^{M_AXI.RID, M_AXI.RUSER, FLUSH_PC[1:0]};

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        flush_pend_d = flush_pend_q;
        beat_pc_d    = push ? beat_pc_q + 32'd4 : beat_pc_q;
        err_d        = err_q || (push && M_AXI.RRESP != 2'b00);
        wr_d         = wr_q + AW'(push);
        rd_d         = rd_q + AW'(pop);
        count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
        case (state_q)
            IDLE: if (issue) begin
                state_d   = ADDR;
                araddr_d  = fetch_pc_q;
                arlen_d   = 8'(beats - 32'd1);
                beat_pc_d = fetch_pc_q;
            end
            // ARVALID cannot be withdrawn, so a flush here only marks the burst for draining
            ADDR: begin
                flush_pend_d = flush_pend_q || FLUSH;
                if (M_AXI.ARREADY) begin
                    state_d      = (flush_pend_q || FLUSH) ? DRAIN : DATA;
                    flush_pend_d = 1'b0;
                end
            end
            // A flush on the RLAST beat needs no drain: the burst is already complete
            DATA: if (beat && M_AXI.RLAST) begin
                state_d    = IDLE;
                fetch_pc_d = araddr_q + ((32'(arlen_q) + 32'd1) << 2);
            end else if (FLUSH) begin
                state_d = DRAIN;
            end
            DRAIN: state_d = (beat && M_AXI.RLAST) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
        if (FLUSH) begin
            fetch_pc_d = {FLUSH_PC[31:2], 2'b00};
            wr_d       = '0;
            rd_d       = '0;
            count_d    = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            fetch_pc_q   <= {C_RESET_PC[31:2], 2'b00};
            araddr_q     <= '0;
            arlen_q      <= '0;
            beat_pc_q    <= '0;
            flush_pend_q <= 1'b0;
            err_q        <= 1'b0;
            count_q      <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            beat_pc_q    <= beat_pc_d;
            flush_pend_q <= flush_pend_d;
            err_q        <= err_d;
            count_q      <= count_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            inst_mem[wr_q] <= M_AXI.RDATA;
            pc_mem[wr_q]   <= beat_pc_q;
        end
    end
endmodule

// File: tb/tb_inst_prefetch.sv
// tb_inst_prefetch: scoreboard bench for inst_prefetch with a randomized AXI slave and a stream-level reference model.
module tb_inst_prefetch;
    localparam int          BL    = 4;
    localparam int          DEPTH = 8;
    localparam logic [31:0] RPC   = 32'h0;

    logic        CLK = 0, RST = 0, EXEC = 0, FLUSH = 0, INST_READY = 0;
    logic [31:0] FLUSH_PC = '0;
    logic        INST_VALID, BUSY, ERR;
    logic [31:0] INST, INST_PC;

    inst_prefetch_if axi ();

    inst_prefetch #(.C_BURST_LEN(BL), .C_FIFO_DEPTH(DEPTH), .C_RESET_PC(RPC)) dut (
        .CLK(CLK), .RST(RST), .EXEC(EXEC), .FLUSH(FLUSH), .FLUSH_PC(FLUSH_PC),
        .INST_VALID(INST_VALID), .INST_READY(INST_READY), .INST(INST), .INST_PC(INST_PC),
        .BUSY(BUSY), .ERR(ERR), .M_AXI(axi)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // ---------------- AXI slave ----------------
    logic        zero_wait = 1, ar_hold = 0, s_busy = 0, hs_ar, hs_r;
    logic [31:0] s_addr, cap_addr;
    logic [7:0]  cap_len;
    int          s_left;

    initial begin
        axi.ARREADY = 0; axi.RVALID = 0; axi.RDATA = 0; axi.RRESP = 0;
        axi.RLAST = 0; axi.RID = '0; axi.RUSER = '0;
        forever begin
            @(negedge CLK);
            hs_ar = axi.ARVALID && axi.ARREADY;
            hs_r = axi.RVALID && axi.RREADY;
            cap_addr = axi.ARADDR;
            cap_len = axi.ARLEN;
            @(posedge CLK);
            #1;
            if (!RST) begin
                s_busy = 0; axi.ARREADY = 0; axi.RVALID = 0; axi.RLAST = 0;
            end else begin
                if (hs_ar) begin
                    s_busy = 1; s_addr = cap_addr; s_left = int'(cap_len) + 1;
                end else if (hs_r) begin
                    s_addr += 4; s_left--;
                    if (s_left == 0) s_busy = 0;
                end
                axi.ARREADY = !s_busy && !ar_hold && (zero_wait || $urandom_range(0, 1) == 1);
                if (!(axi.RVALID && !hs_r)) begin
                    axi.RVALID = s_busy && (zero_wait || $urandom_range(0, 2) != 0);
                    axi.RRESP = ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
                end
                axi.RDATA = mem_word(s_addr);
                axi.RLAST = s_busy && s_left == 1;
            end
        end
    end

    // ---------------- Monitor / scoreboard ----------------
    // The model sees the instruction stream as contiguous words from the last redirect target,
    // fetched in block-bounded chunks; every chunk requested after the last flush must be delivered in order.
    logic [31:0] exp_q[$];
    logic [31:0] model_pc = RPC, hold_addr, last_ar_addr, p;
    logic [7:0]  hold_len, last_ar_len;
    logic        prev_arv = 0, prev_flush = 0, exp_err = 0;
    int          epoch = 0, ar_epoch = -1, ar_rises = 0, pops = 0, n;

    always @(negedge CLK) begin
        if (!RST) begin
            exp_q.delete();
            model_pc = RPC; exp_err = 0; prev_arv = 0; prev_flush = 0; epoch++;
        end else begin
            chk("err_flag", 32'(ERR), 32'(exp_err));
            if (prev_flush) chk("valid_after_flush", 32'(INST_VALID), 32'd0);
            if (axi.ARVALID && !prev_arv) begin
                n = BL - int'((model_pc >> 2) % BL);
                chk("araddr", axi.ARADDR, model_pc);
                chk("arlen", 32'(axi.ARLEN), 32'(n - 1));
                chk("fifo_space", 32'(exp_q.size() + n <= DEPTH), 32'd1);
                for (int i = 0; i < n; i++) exp_q.push_back(model_pc + 32'(4 * i));
                model_pc += 32'(4 * n);
                hold_addr = axi.ARADDR; hold_len = axi.ARLEN;
                last_ar_addr = axi.ARADDR; last_ar_len = axi.ARLEN;
                ar_epoch = epoch; ar_rises++;
            end else if (axi.ARVALID) begin
                chk("araddr_stable", axi.ARADDR, hold_addr);
                chk("arlen_stable", 32'(axi.ARLEN), 32'(hold_len));
            end
            prev_arv = axi.ARVALID && !axi.ARREADY;
            if (axi.RVALID && axi.RREADY && !FLUSH && ar_epoch == epoch && axi.RRESP != 2'b00) exp_err = 1;
            if (INST_VALID && INST_READY && !FLUSH) begin
                pops++;
                if (exp_q.size() == 0) chk("unexpected_pop", INST_PC, 32'hFFFF_FFFF);
                else begin
                    p = exp_q.pop_front();
                    chk("inst_pc", INST_PC, p);
                    chk("inst_word", INST, mem_word(p));
                end
            end
            prev_flush = FLUSH;
            if (FLUSH) begin
                exp_q.delete();
                model_pc = {FLUSH_PC[31:2], 2'b00};
                epoch++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic flush_to(input logic [31:0] t);
        FLUSH_PC = t; FLUSH = 1;
        tick();
        FLUSH = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(INST_VALID), 32'd0);
        chk({tag, "_inst"}, INST, 32'd0);
        chk({tag, "_pc"}, INST_PC, 32'd0);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_err"}, 32'(ERR), 32'd0);
        chk({tag, "_arvalid"}, 32'(axi.ARVALID), 32'd0);
        chk({tag, "_rready"}, 32'(axi.RREADY), 32'd0);
    endtask

    int lat, base, k;
    logic did_rst;

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RST = 1; INST_READY = 1;
        tick();
        // First fetch latency with a zero-wait slave
        EXEC = 1; lat = 0;
        while (lat < 20) begin
            @(posedge CLK); lat++; #2;
            if (INST_VALID) break;
        end
        chk("first_latency", 32'(lat), 32'd3);
        chk("first_inst_pc", INST_PC, RPC);
        repeat (30) tick();

        // Redirect to an unaligned-in-block target while idle
        EXEC = 0; k = 0;
        while (BUSY && k < 30) begin tick(); k++; end
        chk("idle_before_flush", 32'(BUSY), 32'd0);
        flush_to(32'h0000_001F);
        EXEC = 1; base = ar_rises; k = 0;
        while (ar_rises == base && k < 20) begin tick(); k++; end
        chk("ar1c_addr", last_ar_addr, 32'h1C);
        chk("ar1c_len", 32'(last_ar_len), 32'd0);
        k = 0;
        while (ar_rises == base + 1 && k < 20) begin tick(); k++; end
        chk("ar20_addr", last_ar_addr, 32'h20);
        chk("ar20_len", 32'(last_ar_len), 32'd3);
        repeat (20) tick();

        // Consumer stalled: FIFO fills with exactly two bursts
        INST_READY = 0;
        flush_to(32'h200);
        base = ar_rises;
        repeat (40) tick();
        chk("two_bursts", 32'(ar_rises - base), 32'd2);
        chk("full_valid", 32'(INST_VALID), 32'd1);
        INST_READY = 1;
        tick();
        INST_READY = 0;
        repeat (10) tick();
        chk("no_third_ar", 32'(ar_rises - base), 32'd2);
        INST_READY = 1; k = 0;
        while (ar_rises - base == 2 && k < 20) begin tick(); k++; end
        chk("third_ar_after_pops", 32'(ar_rises - base), 32'd3);
        chk("third_ar_addr", last_ar_addr, 32'h220);

        // Flush while the address phase is stalled
        ar_hold = 1; k = 0;
        while (!axi.ARVALID && k < 40) begin tick(); k++; end
        chk("arvalid_held", 32'(axi.ARVALID), 32'd1);
        flush_to(32'h100);
        repeat (5) tick();
        chk("arvalid_still", 32'(axi.ARVALID), 32'd1);
        base = ar_rises; ar_hold = 0; k = 0;
        while (ar_rises == base && k < 40) begin tick(); k++; end
        chk("ar_after_drain", last_ar_addr, 32'h100);
        chk("ar_after_drain_len", 32'(last_ar_len), 32'd3);

        // Randomized traffic with a mid-burst reset
        zero_wait = 0; did_rst = 0;
        for (int i = 0; i < 2500; i++) begin
            if (i >= 1200 && !did_rst && BUSY) begin
                did_rst = 1; FLUSH = 0;
                @(posedge CLK);
                #3 RST = 0;
                #1 check_reset_outputs("midreset");
                repeat (2) @(posedge CLK);
                #1 RST = 1;
            end
            EXEC = $urandom_range(0, 7) != 0;
            INST_READY = $urandom_range(0, 2) != 0;
            FLUSH = $urandom_range(0, 39) == 0;
            FLUSH_PC = $urandom;
            tick();
        end
        chk("midreset_done", 32'(did_rst), 32'd1);

        // Quiet tail: the stream keeps flowing
        FLUSH = 0; EXEC = 1; INST_READY = 1; base = pops;
        repeat (150) tick();
        chk("tail_progress", 32'(pops - base >= 20), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
